// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller state encoding.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEMWAIT  = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard controller signals; hc is the controller side, tb the driver side.
interface hazard_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  regbits_t         idex_rt;
  logic             idex_dren;
  logic             idex_regwrite;
  logic             idex_halt;
  logic             ex_redirect;
  logic             exmem_dren;
  logic             exmem_dwen;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport hc (
    input  ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dren, idex_regwrite,
           idex_halt, ex_redirect, exmem_dren, exmem_dwen,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, stall_cnt, flush_cnt
  );

  modport tb (
    output ihit, dhit, ifid_rs, ifid_rt, idex_rt, idex_dren, idex_regwrite,
           idex_halt, ex_redirect, exmem_dren, exmem_dwen,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: latch enables and flushes for IF/ID, ID/EX, EX/MEM and PC.
// state    | meaning
// RUN      | normal issue; load-use, redirect, memory-wait and halt evaluated
// MEMWAIT  | full freeze until the MEM access completes (dhit)
// REDIRECT | taken redirect waiting for ihit to flush IF/ID and ID/EX
// HALTED   | core stopped; left only through RST
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  regbits_t         idex_rt,
  input  logic             idex_dren,
  input  logic             idex_regwrite,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state, state_nxt;
  logic mw, lu, run_eval;

  always_comb begin
    mw = (exmem_dren | exmem_dwen) & ~dhit;
    lu = idex_dren & idex_regwrite & (idex_rt != '0) &
         ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    // MEMWAIT falls back to the RUN rules in the cycle the access completes
    run_eval = (state == RUN) | ((state == MEMWAIT) & dhit);

    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;

    if (run_eval) begin
      if (mw) begin
        state_nxt = MEMWAIT;
      end else begin
        if (ex_redirect) begin
          if (ihit) begin
            {pc_en, ifid_en, idex_en, exmem_en} = 4'hf;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end
        end else if (lu) begin
          idex_en    = ihit;
          exmem_en   = ihit;
          idex_flush = ihit;
        end else begin
          {pc_en, ifid_en, idex_en, exmem_en} = {4{ihit}};
        end

        if (idex_halt && ihit)
          state_nxt = HALTED;
        else if (ex_redirect && !ihit)
          state_nxt = REDIRECT;
        else
          state_nxt = RUN;
      end
    end else if (state == REDIRECT) begin
      {pc_en, ifid_en, idex_en, exmem_en} = {4{ihit}};
      ifid_flush = ihit;
      idex_flush = ihit;
      state_nxt  = ihit ? RUN : REDIRECT;
    end

    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'h0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      state <= RUN;
    else
      state <= state_nxt;
  end

  assign halted = (state == HALTED);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (~pc_en & (state != HALTED) & ~RST),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .RST (RST),
    .inc (idex_flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazards, redirect, memory wait, halt, counter saturation.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad = 0;

  hazard_ctrl_if #(.CNT_W(32)) hif ();

  logic       pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4, exmem_en4, halted4;
  logic [3:0] stall_cnt4, flush_cnt4;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .ihit(hif.ihit), .dhit(hif.dhit), .ifid_rs(hif.ifid_rs), .ifid_rt(hif.ifid_rt),
    .idex_rt(hif.idex_rt), .idex_dren(hif.idex_dren), .idex_regwrite(hif.idex_regwrite),
    .idex_halt(hif.idex_halt), .ex_redirect(hif.ex_redirect),
    .exmem_dren(hif.exmem_dren), .exmem_dwen(hif.exmem_dwen),
    .pc_en(hif.pc_en), .ifid_en(hif.ifid_en), .ifid_flush(hif.ifid_flush),
    .idex_en(hif.idex_en), .idex_flush(hif.idex_flush), .exmem_en(hif.exmem_en),
    .halted(hif.halted), .stall_cnt(hif.stall_cnt), .flush_cnt(hif.flush_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .ihit(hif.ihit), .dhit(hif.dhit), .ifid_rs(hif.ifid_rs), .ifid_rt(hif.ifid_rt),
    .idex_rt(hif.idex_rt), .idex_dren(hif.idex_dren), .idex_regwrite(hif.idex_regwrite),
    .idex_halt(hif.idex_halt), .ex_redirect(hif.ex_redirect),
    .exmem_dren(hif.exmem_dren), .exmem_dwen(hif.exmem_dwen),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
    .idex_en(idex_en4), .idex_flush(idex_flush4), .exmem_en(exmem_en4),
    .halted(halted4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {pc_en, ifid_en, idex_en, exmem_en}
  function automatic logic [31:0] en_v();
    return {28'd0, hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en};
  endfunction

  // {ifid_flush, idex_flush}
  function automatic logic [31:0] fl_v();
    return {30'd0, hif.ifid_flush, hif.idex_flush};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    hif.ihit = 1'b0; hif.dhit = 1'b0;
    hif.ifid_rs = '0; hif.ifid_rt = '0; hif.idex_rt = '0;
    hif.idex_dren = 1'b0; hif.idex_regwrite = 1'b0; hif.idex_halt = 1'b0;
    hif.ex_redirect = 1'b0; hif.exmem_dren = 1'b0; hif.exmem_dwen = 1'b0;
  endtask

  // Inputs for the scenario are set before calling; reset is released between edges.
  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    clr_in();
    hif.ihit = 1'b1;
    RST = 1'b1;
    #2;
    check("rst_en_forced", en_v(), 0);
    check("rst_fl_forced", fl_v(), 0);
    check("rst_halted", 32'(hif.halted), 0);
    check("rst_stall", hif.stall_cnt, 0);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      check("norm_en", en_v(), 32'hf);
      check("norm_fl", fl_v(), 0);
      tick();
    end
    check("norm_stall", hif.stall_cnt, 0);
    check("norm_flush", hif.flush_cnt, 0);

    // load-use through Rs, then rt=0 (no hazard), then through Rt
    clr_in();
    hif.ihit = 1'b1; hif.idex_dren = 1'b1; hif.idex_regwrite = 1'b1;
    hif.idex_rt = 5'd8; hif.ifid_rs = 5'd8;
    do_reset();
    check("lu_en", en_v(), 32'h3);
    check("lu_fl", fl_v(), 32'h1);
    tick();
    check("lu_stall", hif.stall_cnt, 1);
    check("lu_flush", hif.flush_cnt, 1);
    hif.idex_rt = 5'd0; hif.ifid_rs = 5'd0;
    #1;
    check("lu_r0_en", en_v(), 32'hf);
    check("lu_r0_fl", fl_v(), 0);
    tick();
    check("lu_r0_stall", hif.stall_cnt, 1);
    hif.idex_rt = 5'd9; hif.ifid_rt = 5'd9; hif.ifid_rs = 5'd3;
    #1;
    check("lu_rt_en", en_v(), 32'h3);
    tick();
    check("lu_rt_flush", hif.flush_cnt, 2);

    // memory wait on a load: 3 frozen cycles, released on dhit
    clr_in();
    hif.ihit = 1'b1; hif.exmem_dren = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("mw_en", en_v(), 0);
      check("mw_fl", fl_v(), 0);
      tick();
    end
    hif.dhit = 1'b1;
    #1;
    check("mw_done_en", en_v(), 32'hf);
    check("mw_stall", hif.stall_cnt, 3);
    tick();
    check("mw_stall_after", hif.stall_cnt, 3);

    // store wait coinciding with a redirect: freeze, then redirect on dhit
    clr_in();
    hif.ihit = 1'b1; hif.exmem_dwen = 1'b1; hif.ex_redirect = 1'b1;
    do_reset();
    check("mwr_freeze_en", en_v(), 0);
    check("mwr_freeze_fl", fl_v(), 0);
    tick();
    hif.dhit = 1'b1;
    #1;
    check("mwr_dhit_en", en_v(), 32'hf);
    check("mwr_dhit_fl", fl_v(), 32'h3);
    tick();
    check("mwr_flush", hif.flush_cnt, 1);

    // redirect without ihit: pending flush survives ex_redirect dropping
    clr_in();
    hif.ex_redirect = 1'b1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      check("rd_wait_en", en_v(), 0);
      check("rd_wait_fl", fl_v(), 0);
      tick();
    end
    hif.ex_redirect = 1'b0; hif.ihit = 1'b1;
    #1;
    check("rd_hit_en", en_v(), 32'hf);
    check("rd_hit_fl", fl_v(), 32'h3);
    tick();
    check("rd_flush", hif.flush_cnt, 1);
    check("rd_stall", hif.stall_cnt, 2);
    check("rd_after_fl", fl_v(), 0);
    // redirect with ihit coinciding with load-use: one flush, no bubble stall
    hif.ex_redirect = 1'b1; hif.idex_dren = 1'b1; hif.idex_regwrite = 1'b1;
    hif.idex_rt = 5'd4; hif.ifid_rs = 5'd4;
    #1;
    check("rdlu_en", en_v(), 32'hf);
    check("rdlu_fl", fl_v(), 32'h3);
    tick();
    check("rdlu_flush", hif.flush_cnt, 2);
    check("rdlu_stall", hif.stall_cnt, 2);

    // reset mid-REDIRECT discards the pending flush
    clr_in();
    hif.ex_redirect = 1'b1;
    do_reset();
    tick();
    #2;
    RST = 1'b1;
    #1;
    RST = 1'b0;
    hif.ex_redirect = 1'b0; hif.ihit = 1'b1;
    #1;
    check("rdrst_en", en_v(), 32'hf);
    check("rdrst_fl", fl_v(), 0);

    // halt: sticky over random inputs, counters frozen, async reset clears
    clr_in();
    hif.ihit = 1'b1; hif.idex_halt = 1'b1;
    do_reset();
    check("halt_issue_en", en_v(), 32'hf);
    check("halt_pre", 32'(hif.halted), 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      hif.ihit = 1'($urandom_range(0, 1));
      hif.dhit = 1'($urandom_range(0, 1));
      hif.ex_redirect = 1'($urandom_range(0, 1));
      hif.exmem_dren = 1'($urandom_range(0, 1));
      hif.idex_halt = 1'($urandom_range(0, 1));
      hif.idex_dren = 1'b1; hif.idex_regwrite = 1'b1;
      hif.idex_rt = 5'($urandom_range(1, 31)); hif.ifid_rs = hif.idex_rt;
      #1;
      check("halt_sticky", 32'(hif.halted), 1);
      check("halt_en", en_v(), 0);
      check("halt_fl", fl_v(), 0);
      tick();
    end
    check("halt_stall", hif.stall_cnt, 0);
    check("halt_flush", hif.flush_cnt, 0);
    #2;
    RST = 1'b1;
    #1;
    check("halt_async_rst", 32'(hif.halted), 0);
    check("halt_rst_cnt", hif.stall_cnt, 0);

    // saturation: idle pipeline (ihit=0) stalls every cycle
    clr_in();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) check("sat_at_15", 32'(stall_cnt4), 15);
    end
    check("sat_hold", 32'(stall_cnt4), 15);
    check("sat_wide", hif.stall_cnt, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
